hazard_ctrl_pip: RTL
====================

# hazard_ctrl_pip

Pipeline hazard and PC-sequencing controller for the 5-stage pipelined MIPS core. Each cycle it decides whether the program counter and IF/ID register advance, hold, or are redirected, and whether the ID and EX stages are squashed. It covers post-reset fetch hold, load-use interlock, jump and taken-branch redirect, and multi-cycle multiply/divide (MDU) interlock. Its `stall_f` output drives the PC's `EN` input: high means hold, low means advance.

## Interface
- `RW`, 5: register address width.
- `RST_HOLD`, 2: number of fetch-hold cycles after `RST` deasserts. Range 0–15.
- `MDU_LAT`, 4: number of cycles the MDU result is busy after start. Range 1–15.

- `CLK`  in  1: clock; all state changes on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `rs_d`  in  RW: rs field of the instruction in ID.
- `rt_d`  in  RW: rt field of the instruction in ID.
- `use_rt_d`  in  1: the ID instruction reads rt as a source.
- `memread_e`  in  1: the EX instruction is a load.
- `rt_e`  in  RW: destination register of the EX load.
- `jump_d`  in  1: the ID instruction is j/jal.
- `branch_e`  in  1: the branch in EX resolved taken.
- `mdu_start_e`  in  1: a mult/div entered EX this cycle. Never coincides with `branch_e`.
- `mdu_use_d`  in  1: the ID instruction reads HI/LO or is itself a mult/div.
- `stall_f`  out  1: hold the PC.
- `stall_d`  out  1: hold IF/ID.
- `flush_d`  out  1: clear IF/ID to a bubble.
- `flush_e`  out  1: clear ID/EX to a bubble.
- `pc_sel`  out  2: next-PC source. 00 = PC+4, 01 = jump target, 10 = branch target.
- `mdu_busy`  out  1: the MDU result is not yet valid.
- `ready`  out  1: the controller is in RUN.

## Operation
- States:
  - RESET: held while `RST` is high.
  - HOLD: counts down `RST_HOLD` cycles.
  - RUN.
- Transitions:
  - Any state with `RST` high → RESET. The hold counter is loaded with `RST_HOLD`, the MDU counter is cleared, and `mdu_busy` goes to 0.
  - RESET with `RST` low → HOLD, or → RUN directly if `RST_HOLD` is 0.
  - HOLD → RUN when the hold counter reaches 0.
- RESET and HOLD outputs: `stall_f`=1, `stall_d`=1, `flush_d`=1, `flush_e`=1, `pc_sel`=00, `ready`=0.
- RUN outputs are combinational from the current inputs plus registered state. Conditions, highest priority first:
  1. Branch, when `branch_e`=1: `pc_sel`=10, `flush_d`=1, `flush_e`=1, `stall_f`=0, `stall_d`=0. This overrides every stall and any jump.
  2. MDU interlock, when `mdu_busy` && `mdu_use_d`: `stall_f`=1, `stall_d`=1, `flush_e`=1, `pc_sel`=00.
  3. Load-use, when `memread_e` && `rt_e`≠0 && (`rt_e`==`rs_d` || (`use_rt_d` && `rt_e`==`rt_d`)): `stall_f`=1, `stall_d`=1, `flush_e`=1, `pc_sel`=00.
  4. Jump, when `jump_d`: `pc_sel`=01, `flush_d`=1. There is no delay slot. If a stall from condition 2 or 3 is active, the jump is suppressed that cycle and taken once the stall clears, because the jump is still held in ID.
  5. Otherwise: all outputs are 0 and `pc_sel`=00.
- MDU counter (4-bit):
  - `mdu_start_e` in RUN loads the counter with `MDU_LAT`.
  - It decrements each cycle while nonzero.
  - `mdu_busy` = (counter ≠ 0).
  - A start while the counter is nonzero reloads it with `MDU_LAT`.
  - A branch does not clear the counter, since the MDU instruction is older than the branch.
- Register 0 never causes a load-use stall.

## Timing
- Hazard decisions have zero latency: outputs respond in the same cycle as the inputs.
- State, hold counter and MDU counter update on the rising edge of `CLK`.
- `RST` sampled high at edge N: from cycle N+1, `ready`=0 and all stall and flush outputs are 1.
- `RST` sampled low at edge M: `ready`=1 from cycle M+1+`RST_HOLD`.
- `mdu_start_e` high in cycle T: `mdu_busy` is 1 for cycles T+1 … T+`MDU_LAT`, then 0.
- A load-use stall lasts exactly 1 cycle, because the load leaves EX.
- `stall_*` and `flush_*` are never both high for the same register in RUN, except `flush_e` together with `stall_f`/`stall_d`, which inserts a bubble.

## Test plan
- Reset hold: assert `RST` for 3 cycles, then release, with `RST_HOLD`=2. Required: `stall_f`=1 during reset and the 2 following cycles; `ready` rises in the 3rd cycle after release; `pc_sel`=00 throughout.
- Load-use stall: `memread_e`=1, `rt_e`=8, `rs_d`=8. Required: `stall_f`=1, `stall_d`=1, `flush_e`=1 for exactly 1 cycle. Repeat with `rt_e`=0: no stall.
- Branch overrides stall: drive load-use match and `branch_e`=1 together. Required: `pc_sel`=10, `flush_d`=1, `flush_e`=1, `stall_f`=0.
- Jump under load-use stall: `jump_d`=1 with load-use active in cycle T. Required: `pc_sel`=00 in T; in T+1, with the stall cleared, `pc_sel`=01 and `flush_d`=1.
- MDU interlock: `mdu_start_e` pulse in cycle 0, then `mdu_use_d`=1 held, with `MDU_LAT`=4. Required: `stall_f`=1 in cycles 1–4 and 0 in cycle 5; `mdu_busy` falls after cycle 4.
- Reset mid-operation: assert `RST` while `mdu_busy`=1 and `jump_d`=1. Required: next cycle `mdu_busy`=0, `pc_sel`=00, `ready`=0; the MDU counter stays 0 after release.

Source files
------------

// File: rtl/hazard_ctrl_pip.sv
// Hazard and PC-sequencing controller for the 5-stage MIPS pipeline.
// Handles post-reset fetch hold, load-use and MDU interlocks, jump and branch redirect.
module hazard_ctrl_pip #(
  parameter int RW       = 5,
  parameter int RST_HOLD = 2,
  parameter int MDU_LAT  = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [RW-1:0] rs_d,
  input  logic [RW-1:0] rt_d,
  input  logic          use_rt_d,
  input  logic          memread_e,
  input  logic [RW-1:0] rt_e,
  input  logic          jump_d,
  input  logic          branch_e,
  input  logic          mdu_start_e,
  input  logic          mdu_use_d,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_d,
  output logic          flush_e,
  output logic [1:0]    pc_sel,
  output logic          mdu_busy,
  output logic          ready
);

  // state   | meaning
  // S_RESET | RST asserted, pipeline frozen and squashed
  // S_HOLD  | fetch held while hold_cnt drains after reset release
  // S_RUN   | normal hazard resolution
  typedef enum logic [1:0] {S_RESET, S_HOLD, S_RUN} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD);
  localparam logic [3:0] MDU_INIT  = 4'(MDU_LAT);

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  state_t     state;
  logic [3:0] hold_cnt;
  logic [3:0] mdu_cnt;
  logic       load_use;
  logic       mdu_stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_RESET;
      hold_cnt <= HOLD_INIT;
      mdu_cnt  <= 4'd0;
      ready    <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          if (hold_cnt == 4'd0) begin
            state <= S_RUN;
            ready <= 1'b1;
          end else begin
            state <= S_HOLD;
          end
        end
        // Leave on the last hold cycle so RUN starts exactly RST_HOLD cycles after release.
        S_HOLD: begin
          if (hold_cnt <= 4'd1) begin
            state    <= S_RUN;
            hold_cnt <= 4'd0;
            ready    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        S_RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= S_RESET;
          ready <= 1'b0;
        end
      endcase

      // Branches leave the counter alone: the mult/div is older than the branch.
      if (state == S_RUN && mdu_start_e) begin
        mdu_cnt <= MDU_INIT;
      end else if (mdu_cnt != 4'd0) begin
        mdu_cnt <= mdu_cnt - 4'd1;
      end
    end
  end

  assign mdu_busy  = (mdu_cnt != 4'd0);
  assign mdu_stall = mdu_busy && mdu_use_d;
  assign load_use  = memread_e && (rt_e != '0) &&
                     ((rt_e == rs_d) || (use_rt_d && (rt_e == rt_d)));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    pc_sel  = PC_SEQ;
    if (state != S_RUN) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (branch_e) begin
      pc_sel  = PC_BRANCH;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mdu_stall || load_use) begin
      // A jump held in ID is simply retried once the stall clears.
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (jump_d) begin
      pc_sel  = PC_JUMP;
      flush_d = 1'b1;
    end
  end

endmodule
